// File: rtl/s_apb_regfile.sv
// APB slave register file with programmable wait states.
// Byte-strobed writes, address range checking and a write-commit pulse.
`ifndef APB_AW
`define APB_AW 32
`endif
`ifndef APB_DW
`define APB_DW 32
`endif
`ifndef APB_STRBW
`define APB_STRBW 4
`endif

module s_apb_regfile #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0
) (
    input  logic                           s_apb_pclk_i,
    input  logic                           s_apb_presetn_i,
    input  logic [`APB_AW-1:0]             s_apb_paddr_i,
    input  logic                           s_apb_psel_i,
    input  logic                           s_apb_penable_i,
    input  logic                           s_apb_pwrite_i,
    input  logic [`APB_DW-1:0]             s_apb_pwdata_i,
    input  logic [`APB_STRBW-1:0]          s_apb_pstrb_i,
    output logic                           s_apb_pready_o,
    output logic [`APB_DW-1:0]             s_apb_prdata_o,
    output logic                           s_apb_pslverr_o,
    output logic [NUM_REGS*`APB_DW-1:0]    regs_o,
    output logic                           wr_pulse_o,
    output logic [$clog2(NUM_REGS)-1:0]    wr_idx_o
);

    localparam int unsigned IW = $clog2(NUM_REGS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic [`APB_AW-1:0]  addr_q;
    logic                write_q;
    logic [`APB_DW-1:0]  regs_q [NUM_REGS];
    logic                wr_pulse_q;
    logic [IW-1:0]       wr_idx_q;

    logic [IW-1:0]       idx;
    logic                addr_ok;
    logic                pready;
    logic                wr_en;
    logic [`APB_DW-1:0]  wr_data_d;

    // Word aligned and no bits set above the register window.
    assign idx     = addr_q[2 +: IW];
    assign addr_ok = (addr_q[1:0] == 2'b00) &&
                     (addr_q[`APB_AW-1:IW+2] == '0);

    assign pready = (state_q == ACCESS) && (cnt_q == 4'd0) &&
                    s_apb_psel_i && s_apb_penable_i;
    assign wr_en  = pready && write_q && addr_ok;

    always_comb begin
        wr_data_d = regs_q[idx];
        for (int i = 0; i < `APB_STRBW; i++) begin
            if (s_apb_pstrb_i[i]) begin
                wr_data_d[8*i +: 8] = s_apb_pwdata_i[8*i +: 8];
            end
        end
    end

    always_ff @(posedge s_apb_pclk_i or negedge s_apb_presetn_i) begin
        if (!s_apb_presetn_i) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            write_q    <= 1'b0;
            wr_pulse_q <= 1'b0;
            wr_idx_q   <= '0;
        end else begin
            wr_pulse_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (s_apb_psel_i && !s_apb_penable_i) begin
                        state_q <= ACCESS;
                        addr_q  <= s_apb_paddr_i;
                        write_q <= s_apb_pwrite_i;
                        cnt_q   <= WAIT_LD;
                    end
                end
                ACCESS: begin
                    if (!s_apb_psel_i || pready) begin
                        state_q <= IDLE;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                    if (wr_en) begin
                        wr_pulse_q <= 1'b1;
                        wr_idx_q   <= idx;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge s_apb_pclk_i or negedge s_apb_presetn_i) begin
        if (!s_apb_presetn_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= RESET_VAL;
            end
        end else if (wr_en) begin
            regs_q[idx] <= wr_data_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[32*k +: 32] = regs_q[k];
        end
    end

    assign s_apb_pready_o  = pready;
    assign s_apb_pslverr_o = pready && !addr_ok;
    assign s_apb_prdata_o  = (pready && !write_q && addr_ok) ?
                             regs_q[idx] : '0;
    assign wr_pulse_o      = wr_pulse_q;
    assign wr_idx_o        = wr_idx_q;

endmodule

// File: tb/tb_s_apb_regfile.sv
// Bench for s_apb_regfile: two instances (1 wait / 8 regs, 0 wait / 4 regs).
// Expected responses are queued per instance and checked when pready rises.
`timescale 1ns/1ps
module tb_s_apb_regfile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n = 1'b0;
    logic [31:0]  paddr = '0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic         penable = 1'b0;
    logic         pwrite = 1'b0;
    logic         psel_a = 1'b0;
    logic         psel_b = 1'b0;

    logic         pready_a, pslverr_a, wr_pulse_a;
    logic [31:0]  prdata_a;
    logic [255:0] regs_a;
    logic [2:0]   idx_a;
    logic         pready_b, pslverr_b, wr_pulse_b;
    logic [31:0]  prdata_b;
    logic [127:0] regs_b;
    logic [1:0]   idx_b;

    s_apb_regfile #(
        .NUM_REGS(8), .WAIT_CYCLES(1), .RESET_VAL(32'h0)
    ) u_a (
        .s_apb_pclk_i(clk), .s_apb_presetn_i(rst_n),
        .s_apb_paddr_i(paddr), .s_apb_psel_i(psel_a),
        .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite),
        .s_apb_pwdata_i(pwdata), .s_apb_pstrb_i(pstrb),
        .s_apb_pready_o(pready_a), .s_apb_prdata_o(prdata_a),
        .s_apb_pslverr_o(pslverr_a), .regs_o(regs_a),
        .wr_pulse_o(wr_pulse_a), .wr_idx_o(idx_a)
    );

    s_apb_regfile #(
        .NUM_REGS(4), .WAIT_CYCLES(0), .RESET_VAL(32'h1234_5678)
    ) u_b (
        .s_apb_pclk_i(clk), .s_apb_presetn_i(rst_n),
        .s_apb_paddr_i(paddr), .s_apb_psel_i(psel_b),
        .s_apb_penable_i(penable), .s_apb_pwrite_i(pwrite),
        .s_apb_pwdata_i(pwdata), .s_apb_pstrb_i(pstrb),
        .s_apb_pready_o(pready_b), .s_apb_prdata_o(prdata_b),
        .s_apb_pslverr_o(pslverr_b), .regs_o(regs_b),
        .wr_pulse_o(wr_pulse_b), .wr_idx_o(idx_b)
    );

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea, eb;
    int          passed = 0;
    int          total = 0;
    logic [31:0] mreg_a [8];
    logic [31:0] mreg_b [4];

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [255:0] pack_a();
        logic [255:0] v;
        for (int k = 0; k < 8; k++) v[32*k +: 32] = mreg_a[k];
        return v;
    endfunction

    function automatic logic [255:0] pack_b();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 4; k++) v[32*k +: 32] = mreg_b[k];
        return v;
    endfunction

    // Scoreboard monitor: pops one expectation per pready pulse.
    always @(negedge clk) begin
        if (pready_a) begin
            if (qa.size() == 0) begin
                total++;
                $display("FAIL a_unexpected_pready: got 1 expected 0");
            end else begin
                ea = qa.pop_front();
                chk("a_prdata", prdata_a, ea.rd);
                chk("a_pslverr", pslverr_a, ea.err);
            end
        end else begin
            chk("a_idle_err_rd", {pslverr_a, prdata_a}, 33'h0);
        end
        if (pready_b) begin
            if (qb.size() == 0) begin
                total++;
                $display("FAIL b_unexpected_pready: got 1 expected 0");
            end else begin
                eb = qb.pop_front();
                chk("b_prdata", prdata_b, eb.rd);
                chk("b_pslverr", pslverr_b, eb.err);
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after completion.
    task automatic xfer(input bit b, input logic [31:0] addr,
                        input bit wr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [31:0] exp_rd,
                        input bit exp_err, input int exp_cyc);
        int   cyc;
        bit   seen;
        exp_t e;
        e.rd  = exp_rd;
        e.err = exp_err;
        if (b) qb.push_back(e);
        else qa.push_back(e);
        paddr   = addr;
        pwrite  = wr;
        pwdata  = ~wd;
        pstrb   = ~st;
        penable = 1'b0;
        if (b) psel_b = 1'b1;
        else psel_a = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        pwdata  = wd;
        pstrb   = st;
        cyc  = 2;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (b ? pready_b : pready_a) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("latency", seen ? cyc : -1, exp_cyc);
        @(posedge clk); #1;
        psel_a  = 1'b0;
        psel_b  = 1'b0;
        penable = 1'b0;
        chk("wr_pulse", b ? wr_pulse_b : wr_pulse_a, wr && !exp_err);
        if (wr && !exp_err)
            chk("wr_idx", b ? idx_b : idx_a, b ? addr[3:2] : addr[4:2]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 8; k++) mreg_a[k] = 32'h0;
        for (int k = 0; k < 4; k++) mreg_b[k] = 32'h1234_5678;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pready", {pready_a, pready_b}, 2'b00);
        chk("rst_pulse", {wr_pulse_a, wr_pulse_b}, 2'b00);
        chk("rst_idx", {idx_a, idx_b}, 5'h0);
        chk("rst_regs_a", regs_a, pack_a());
        chk("rst_regs_b", regs_b, pack_b());
        rst_n = 1'b1;
        @(posedge clk); #1;

        xfer(0, 32'h04, 1, 32'hDEAD_BEEF, 4'hF, 32'h0, 0, 3);
        mreg_a[1] = 32'hDEAD_BEEF;
        chk("regs_full_wr", regs_a, pack_a());
        @(posedge clk); #1;
        chk("pulse_one_cycle", wr_pulse_a, 1'b0);
        chk("idx_holds", idx_a, 3'd1);

        xfer(0, 32'h04, 1, 32'h0000_00AA, 4'b0001, 32'h0, 0, 3);
        mreg_a[1] = 32'hDEAD_BEAA;
        chk("regs_byte_wr", regs_a, pack_a());
        xfer(0, 32'h04, 0, 32'h0, 4'h0, 32'hDEAD_BEAA, 0, 3);

        xfer(0, 32'h20, 0, 32'h0, 4'h0, 32'h0, 1, 3);
        xfer(0, 32'h06, 1, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, 3);
        xfer(0, 32'h1000_0004, 0, 32'h0, 4'h0, 32'h0, 1, 3);
        chk("regs_after_err", regs_a, pack_a());

        xfer(0, 32'h1C, 1, 32'h1122_3344, 4'b1010, 32'h0, 0, 3);
        mreg_a[7] = 32'h1100_3300;
        chk("regs_strb_1010", regs_a, pack_a());
        xfer(0, 32'h1C, 0, 32'h0, 4'h0, 32'h1100_3300, 0, 3);
        xfer(0, 32'h08, 1, 32'hFFFF_FFFF, 4'h0, 32'h0, 0, 3);
        chk("regs_strb_0", regs_a, pack_a());

        // Abort in the wait cycle, then an access phase with no setup.
        paddr  = 32'h0C;
        pwrite = 1'b1;
        pwdata = 32'hCAFE_F00D;
        pstrb  = 4'hF;
        psel_a = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        chk("abort_wait_pready", pready_a, 1'b0);
        psel_a = 1'b0;
        @(posedge clk); #1;
        psel_a = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("no_setup_pready", {pready_a, wr_pulse_a}, 2'b00);
        end
        @(posedge clk); #1;
        psel_a  = 1'b0;
        penable = 1'b0;
        chk("regs_after_abort", regs_a, pack_a());
        xfer(0, 32'h0C, 0, 32'h0, 4'h0, 32'h0, 0, 3);

        xfer(1, 32'h00, 1, 32'h0000_0001, 4'hF, 32'h0, 0, 2);
        xfer(1, 32'h00, 0, 32'h0, 4'h0, 32'h0000_0001, 0, 2);
        mreg_b[0] = 32'h0000_0001;
        xfer(1, 32'h04, 0, 32'h0, 4'h0, 32'h1234_5678, 0, 2);
        xfer(1, 32'h10, 0, 32'h0, 4'h0, 32'h0, 1, 2);
        chk("regs_b", regs_b, pack_b());

        // Reset while pready is high on a write to 0x08.
        qa.push_back('0);
        paddr   = 32'h08;
        pwrite  = 1'b1;
        pwdata  = 32'h5555_5555;
        pstrb   = 4'hF;
        psel_a  = 1'b1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        chk("pre_rst_pready", pready_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_out", {pready_a, pslverr_a, wr_pulse_a}, 3'b000);
        psel_a  = 1'b0;
        penable = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) mreg_a[k] = 32'h0;
        for (int k = 0; k < 4; k++) mreg_b[k] = 32'h1234_5678;
        chk("regs_a_after_rst", regs_a, pack_a());
        chk("regs_b_after_rst", regs_b, pack_b());
        chk("idx_after_rst", {idx_a, idx_b}, 5'h0);
        @(posedge clk); #1;
        xfer(0, 32'h08, 1, 32'h0BAD_F00D, 4'hF, 32'h0, 0, 3);
        xfer(0, 32'h08, 0, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 3);

        repeat (2) @(posedge clk);
        #1;
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
